// File: rtl/stream_timing_recover.sv
// Receive-side framing checker: validates sof/eol against the configured geometry and re-derives col/row.
// Optional error counter is enabled with STREAM_TIMING_RECOVER_ERR_CNT_EN.
module stream_timing_recover #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eol,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_sticky,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_col,
  output logic [9:0]        out_row,
  output logic              out_sof,
  output logic              out_eol,
  output logic              locked,
  output logic              frame_done,
  output logic              err_pulse,
  output logic              err_line_sticky,
  output logic              err_frame_sticky
`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam logic [9:0] COL_LAST = 10'(IMAGE_WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMAGE_HEIGHT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [9:0] ecol, erow, ecol_nxt, erow_nxt;
  logic [9:0] fwd_col, fwd_row;
  logic       fwd, fwd_sof, fwd_eol, fwd_fd;
  logic       line_err, frame_err;
  logic       at_origin;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign at_origin = (ecol == 10'd0) && (erow == 10'd0);

  always_comb begin
    state_nxt = state;
    ecol_nxt  = ecol;
    erow_nxt  = erow;
    fwd_col   = ecol;
    fwd_row   = erow;
    fwd       = 1'b0;
    fwd_sof   = 1'b0;
    fwd_eol   = 1'b0;
    fwd_fd    = 1'b0;
    line_err  = 1'b0;
    frame_err = 1'b0;
    if (in_valid) begin
      unique case (state)
        SEARCH: begin
          if (in_sof && in_eol) begin
            line_err = 1'b1;
          end else if (in_sof) begin
            fwd       = 1'b1;
            fwd_sof   = 1'b1;
            fwd_col   = 10'd0;
            fwd_row   = 10'd0;
            ecol_nxt  = 10'd1;
            erow_nxt  = 10'd0;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof && !at_origin) begin
            // Resync on the stray sof instead of dropping back to SEARCH
            frame_err = 1'b1;
            fwd       = 1'b1;
            fwd_sof   = 1'b1;
            fwd_col   = 10'd0;
            fwd_row   = 10'd0;
            ecol_nxt  = 10'd1;
            erow_nxt  = 10'd0;
          end else if (at_origin && !in_sof) begin
            frame_err = 1'b1;
            state_nxt = SEARCH;
          end else if ((in_eol && ecol != COL_LAST) || (ecol == COL_LAST && !in_eol)) begin
            line_err  = 1'b1;
            state_nxt = SEARCH;
            ecol_nxt  = 10'd0;
            erow_nxt  = 10'd0;
          end else begin
            fwd     = 1'b1;
            fwd_sof = in_sof;
            fwd_eol = in_eol;
            fwd_fd  = (ecol == COL_LAST) && (erow == ROW_LAST);
            if (ecol == COL_LAST) begin
              ecol_nxt = 10'd0;
              erow_nxt = (erow == ROW_LAST) ? 10'd0 : erow + 10'd1;
            end else begin
              ecol_nxt = ecol + 10'd1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Output register stage: everything leaves exactly one clock after the accepted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= SEARCH;
      ecol             <= 10'd0;
      erow             <= 10'd0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_col          <= 10'd0;
      out_row          <= 10'd0;
      out_sof          <= 1'b0;
      out_eol          <= 1'b0;
      locked           <= 1'b0;
      frame_done       <= 1'b0;
      err_pulse        <= 1'b0;
      err_line_sticky  <= 1'b0;
      err_frame_sticky <= 1'b0;
    end else begin
      state            <= state_nxt;
      ecol             <= ecol_nxt;
      erow             <= erow_nxt;
      out_valid        <= fwd;
      out_sof          <= fwd_sof;
      out_eol          <= fwd_eol;
      frame_done       <= fwd_fd;
      locked           <= (state_nxt == LOCKED);
      err_pulse        <= line_err | frame_err;
      err_line_sticky  <= (err_line_sticky & ~clr_sticky) | line_err;
      err_frame_sticky <= (err_frame_sticky & ~clr_sticky) | frame_err;
      if (fwd) begin
        out_data <= in_data;
        out_col  <= fwd_col;
        out_row  <= fwd_row;
      end
    end
  end

`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (line_err || frame_err) begin
      err_cnt <= clr_sticky ? 16'd1 : sat_inc16(err_cnt);
    end else if (clr_sticky) begin
      err_cnt <= 16'd0;
    end
  end
`else
  logic unused_fn;
  assign unused_fn = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_stream_timing_recover.sv
// Self-checking bench for stream_timing_recover with an 8x4 geometry: table of vectors fed
// through a scoreboard queue, plus hand-written reset and error-counter sequences.
module tb_stream_timing_recover;
  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_sof, in_eol, clr_sticky;
  logic [7:0] in_data;
  logic       out_valid, out_sof, out_eol, locked, frame_done, err_pulse;
  logic       err_line_sticky, err_frame_sticky;
  logic [7:0] out_data;
  logic [9:0] out_col, out_row;
`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  stream_timing_recover #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .in_data(in_data), .clr_sticky(clr_sticky), .out_valid(out_valid), .out_data(out_data),
    .out_col(out_col), .out_row(out_row), .out_sof(out_sof), .out_eol(out_eol),
    .locked(locked), .frame_done(frame_done), .err_pulse(err_pulse),
    .err_line_sticky(err_line_sticky), .err_frame_sticky(err_frame_sticky)
`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    string      nm;
    logic       v, sof, eol, clr;
    logic [7:0] d;
    logic       ov, osof, oeol, fd, err, lk, lst, fst;
    logic [9:0] col, row;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fd_seen  = 0;
  int   err_seen = 0;
  logic e_lk, e_lst, e_fst;

  function automatic void add(string nm, logic v, logic sof, logic eol, logic clr, logic [7:0] d,
                              logic ov, logic osof, logic oeol, logic fd, logic err,
                              logic [9:0] col, logic [9:0] row);
    vec_t t;
    t.nm = nm; t.v = v; t.sof = sof; t.eol = eol; t.clr = clr; t.d = d;
    t.ov = ov; t.osof = osof; t.oeol = oeol; t.fd = fd; t.err = err;
    t.lk = e_lk; t.lst = e_lst; t.fst = e_fst; t.col = col; t.row = row;
    tbl.push_back(t);
  endfunction

  function automatic void pix_ok(string nm, int c, int r, logic [7:0] d);
    logic s, e;
    s = (c == 0 && r == 0);
    e = (c == W - 1);
    e_lk = 1'b1;
    add(nm, 1'b1, s, e, 1'b0, d, 1'b1, s, e, (c == W - 1 && r == H - 1), 1'b0, 10'(c), 10'(r));
  endfunction

  function automatic void pix_drop(string nm, logic sof, logic eol, logic [7:0] d);
    add(nm, 1'b1, sof, eol, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
  endfunction

  function automatic void idle(string nm, logic clr);
    if (clr) begin
      e_lst = 1'b0;
      e_fst = 1'b0;
    end
    add(nm, 1'b0, 1'b0, 1'b0, clr, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic check_vec(vec_t e);
    logic [7:0] act, exp;
    act = {out_valid, out_sof, out_eol, frame_done, err_pulse, locked, err_line_sticky, err_frame_sticky};
    exp = {e.ov, e.osof, e.oeol, e.fd, e.err, e.lk, e.lst, e.fst};
    check({e.nm, "_ctrl"}, 32'(act), 32'(exp));
    if (e.ov) check({e.nm, "_pos"}, {4'd0, out_col, out_row, out_data}, {4'd0, e.col, e.row, e.d});
    if (frame_done) fd_seen++;
    if (err_pulse) err_seen++;
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_sof = tbl[i].sof; in_eol = tbl[i].eol;
      in_data = tbl[i].d; clr_sticky = tbl[i].clr;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      check_vec(sb.pop_front());
    end
    tbl.delete();
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic check_all_zero(string nm);
    check(nm, {out_valid, out_sof, out_eol, locked, frame_done, err_pulse, err_line_sticky,
               err_frame_sticky, out_col, out_row, out_data}, 32'd0);
`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
    check({nm, "_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got %0t want < 5ms", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = 8'h00; clr_sticky = 1'b0;
    e_lk = 1'b0; e_lst = 1'b0; e_fst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // stream joins mid-line: everything dropped without error until sof
    pix_drop("midline5", 1'b0, 1'b0, 8'd5);
    pix_drop("midline6", 1'b0, 1'b0, 8'd6);
    pix_drop("midline7", 1'b0, 1'b1, 8'd7);
    run_table();

    // two clean frames, one pixel every 8th clock
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          pix_ok("clean", c, r, 8'(f * 32 + r * 8 + c));
          for (int k = 0; k < 7; k++) idle("gap", 1'b0);
        end
    fd_seen = 0; err_seen = 0;
    run_table();
    check("frame_done_count", 32'(fd_seen), 32'd2);
    check("no_err_clean", 32'(err_seen), 32'd0);

    // short line: eol at col 5 of row 1
    for (int c = 0; c < W; c++) pix_ok("sl_row0", c, 0, 8'(8'h40 + c));
    for (int c = 0; c < 5; c++) pix_ok("sl_row1", c, 1, 8'(8'h50 + c));
    e_lk = 1'b0; e_lst = 1'b1;
    add("short_line", 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    pix_drop("sl_drop6", 1'b0, 1'b0, 8'h56);
    pix_drop("sl_drop7", 1'b0, 1'b1, 8'h57);
    add("search_sof_eol", 1'b1, 1'b1, 1'b1, 1'b0, 8'h58, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    // relock, then stray sof at (3,2)
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) pix_ok("relock", c, r, 8'(8'h60 + r * 8 + c));
    for (int c = 0; c < 3; c++) pix_ok("relock_r2", c, 2, 8'(8'h70 + c));
    e_fst = 1'b1;
    add("unexp_sof", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    for (int c = 1; c < W - 1; c++) pix_ok("resync", c, 0, 8'(8'hB0 + c));
    idle("clr", 1'b1);
    // long line at (7,0) with clr in the same cycle: the error wins
    e_lk = 1'b0; e_lst = 1'b1;
    add("long_clr", 1'b1, 1'b0, 1'b0, 1'b1, 8'hB7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    idle("clr2", 1'b1);
    idle("after_clr", 1'b0);
    run_table();

    // reset pulse mid-frame at (4,1)
    for (int c = 0; c < W; c++) pix_ok("pre_rst_r0", c, 0, 8'(8'hC0 + c));
    for (int c = 0; c < 4; c++) pix_ok("pre_rst_r1", c, 1, 8'(8'hC8 + c));
    run_table();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hCC;
    @(posedge clk);
    #1;
    check_all_zero("rst_mid");
    rst_n = 1'b1; in_valid = 1'b0;
    e_lk = 1'b0; e_lst = 1'b0; e_fst = 1'b0;
    pix_drop("post_rst5", 1'b0, 1'b0, 8'hCD);
    pix_drop("post_rst6", 1'b0, 1'b0, 8'hCE);
    pix_drop("post_rst7", 1'b0, 1'b1, 8'hCF);
    pix_ok("relock2_0", 0, 0, 8'hD0);
    pix_ok("relock2_1", 1, 0, 8'hD1);
    run_table();

`ifdef STREAM_TIMING_RECOVER_ERR_CNT_EN
    check("cnt_zero", 32'(err_cnt), 32'd0);
    in_valid = 1'b1; in_sof = 1'b1; in_eol = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_five", 32'(err_cnt), 32'd5);
    repeat (69995) @(posedge clk);
    #1;
    check("cnt_sat", 32'(err_cnt), 32'h0000FFFF);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_clr_inc", 32'(err_cnt), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_clr", 32'(err_cnt), 32'd0);
    clr_sticky = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
